matrix_keypad_scanner: RTL and testbench

- Parametrised successor to the 4x4 keypad scanner. Scans a ROWS x COLS active-low key matrix one row at a time.
- Debounces press and release over whole scan frames, rejects multi-key (ghost) frames, and emits one event per debounced press.
- Keeps a shift-register history of the last HIST_DEPTH key codes.
- Sits between the keypad pins (after the col synchroniser) and the game/control logic.

---
 rtl/matrix_keypad_scanner_pkg.sv | 43 ++++
 rtl/matrix_keypad_scanner_if.sv | 39 +++
 rtl/matrix_keypad_scanner_row_driver.sv | 121 ++++++++++++
 rtl/matrix_keypad_scanner.sv | 166 ++++++++++++++++
 tb/tb_matrix_keypad_scanner.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_keypad_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_keypad_scanner_pkg
// Purpose  : Shared types and width helpers for the matrix keypad scanner:
//            debounce FSM states, per-frame scan result encoding and the
//            constant functions used to size key codes and counters.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package matrix_keypad_scanner_pkg;

  // Debounce FSM states
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  // Outcome of one complete scan frame
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } frame_res_t;

  // Bits needed to hold the values 0..n-1, never less than one bit so that
  // degenerate parameter choices still yield a legal vector.
  function automatic int clog2_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

  // Key code width: one code per matrix intersection
  function automatic int code_w(input int rows, input int cols);
    return clog2_w(rows * cols);
  endfunction

endpackage : matrix_keypad_scanner_pkg
`default_nettype wire

// File: rtl/matrix_keypad_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : matrix_keypad_scanner_if
// Purpose  : Bundles the keypad pin side (row/col), the history clear and
//            the event/history outputs of the scanner. The master modport is
//            the scanner itself, the slave modport is the pin/consumer side.
// Revision : 1.0 - initial parametrised release
// ============================================================================
interface matrix_keypad_scanner_if #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int HIST_DEPTH = 4
);
  import matrix_keypad_scanner_pkg::*;

  localparam int CODE_W = code_w(ROWS, COLS);
  localparam int HCNT_W = clog2_w(HIST_DEPTH + 1);

  logic [COLS-1:0]            col;
  logic [ROWS-1:0]            row;
  logic                       clear;
  logic                       key_valid;
  logic [CODE_W-1:0]          key_code;
  logic                       ghost;
  logic [HIST_DEPTH*CODE_W-1:0] key_history;
  logic [HCNT_W-1:0]          hist_count;

  modport master (
    input  col, clear,
    output row, key_valid, key_code, ghost, key_history, hist_count
  );

  modport slave (
    output col, clear,
    input  row, key_valid, key_code, ghost, key_history, hist_count
  );

endinterface : matrix_keypad_scanner_if
`default_nettype wire

// File: rtl/matrix_keypad_scanner_row_driver.sv
`default_nettype none
// ============================================================================
// Module   : keypad_row_driver
// Purpose  : Walks a single low row across the matrix, holding each row for
//            SCAN_DIV cycles and sampling the columns on the last one. Folds
//            each row's sample into a per-frame summary (key count saturated
//            at two, first pressed key code) and presents the finished frame,
//            including the final row's sample, on the frame-end cycle.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module keypad_row_driver
  import matrix_keypad_scanner_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 4,
  parameter int CODE_W   = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [COLS-1:0]   col,
  output logic [ROWS-1:0]   row,
  output logic              frame_done,
  output frame_res_t        frame_result,
  output logic [CODE_W-1:0] frame_code
);

  localparam int DIV_W  = clog2_w(SCAN_DIV);
  localparam int RIDX_W = clog2_w(ROWS);
  localparam int COL_W  = clog2_w(COLS);

  logic [DIV_W-1:0]  div;
  logic [RIDX_W-1:0] ridx;
  logic [1:0]        acc_cnt;
  logic [CODE_W-1:0] acc_code;

  logic              sample;
  logic [1:0]        row_hits;
  logic [COL_W-1:0]  first_col;
  logic [2:0]        sum_cnt;
  logic [1:0]        merged_cnt;
  logic [CODE_W-1:0] merged_code;

  assign sample     = (div == DIV_W'(SCAN_DIV - 1));
  assign frame_done = sample && (ridx == RIDX_W'(ROWS - 1));

  // One-cold row drive decoded from the registered row index
  always_comb begin
    row = '1;
    for (int r = 0; r < ROWS; r++) begin
      if (ridx == RIDX_W'(r)) begin
        row[r] = 1'b0;
      end
    end
  end

  // Count low columns on the current row (saturating at two) and find the
  // lowest pressed column; scanning downward leaves the lowest index last.
  always_comb begin
    row_hits  = 2'd0;
    first_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col[c]) begin
        first_col = COL_W'(c);
      end
    end
    for (int c = 0; c < COLS; c++) begin
      if (!col[c] && (row_hits != 2'd2)) begin
        row_hits = row_hits + 2'd1;
      end
    end
  end

  // Merge the current row into the running frame summary; the earliest
  // row with a press keeps ownership of the reported code.
  always_comb begin
    sum_cnt     = {1'b0, acc_cnt} + {1'b0, row_hits};
    merged_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    merged_code = acc_code;
    if ((acc_cnt == 2'd0) && (row_hits != 2'd0)) begin
      merged_code = CODE_W'(ridx) * CODE_W'(COLS) + CODE_W'(first_col);
    end
  end

  // Frame result as seen on the frame-end cycle
  always_comb begin
    frame_code = merged_code;
    if (merged_cnt == 2'd0) begin
      frame_result = NONE;
    end else if (merged_cnt == 2'd1) begin
      frame_result = SINGLE;
    end else begin
      frame_result = MULTI;
    end
  end

  // Divider, row index and frame accumulator; cleared once a frame is consumed
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div      <= '0;
      ridx     <= '0;
      acc_cnt  <= 2'd0;
      acc_code <= '0;
    end else if (sample) begin
      div <= '0;
      if (frame_done) begin
        ridx     <= '0;
        acc_cnt  <= 2'd0;
        acc_code <= '0;
      end else begin
        ridx     <= ridx + 1'b1;
        acc_cnt  <= merged_cnt;
        acc_code <= merged_code;
      end
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule : keypad_row_driver
`default_nettype wire

// File: rtl/matrix_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : matrix_keypad_scanner
// Purpose  : Scans a ROWS x COLS active-low key matrix, debounces presses and
//            releases over whole frames, rejects multi-key (ghost) frames,
//            emits one event per accepted press and keeps a shift-register
//            history of the last HIST_DEPTH key codes.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module matrix_keypad_scanner
  import matrix_keypad_scanner_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 4,
  parameter int DEBOUNCE   = 3,
  parameter int HIST_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  matrix_keypad_scanner_if.master   bus
);

  localparam int CODE_W = code_w(ROWS, COLS);
  localparam int HCNT_W = clog2_w(HIST_DEPTH + 1);
  localparam int CNT_W  = clog2_w(DEBOUNCE + 1);
  localparam int HIST_W = HIST_DEPTH * CODE_W;

  logic [ROWS-1:0]   row_drv;
  logic              frame_done;
  frame_res_t        frame_result;
  logic [CODE_W-1:0] frame_code;

  state_t            state;
  logic [CODE_W-1:0] cand;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              debounce_met;
  logic              report;

  logic              key_valid_q;
  logic              ghost_q;
  logic [CODE_W-1:0] key_code_q;
  logic [HIST_W-1:0] hist;
  logic [HIST_W-1:0] hist_shifted;
  logic [HCNT_W-1:0] hist_cnt;

  keypad_row_driver #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV),
    .CODE_W   (CODE_W)
  ) u_row_driver (
    .clk          (clk),
    .resetn       (resetn),
    .col          (bus.col),
    .row          (row_drv),
    .frame_done   (frame_done),
    .frame_result (frame_result),
    .frame_code   (frame_code)
  );

  assign cnt_inc      = cnt + 1'b1;
  assign debounce_met = (cnt_inc == CNT_W'(DEBOUNCE));

  // A press is accepted when the last required identical frame arrives
  assign report = frame_done && (state == S_DEBOUNCE) &&
                  (frame_result == SINGLE) && (frame_code == cand) &&
                  debounce_met;

  // History with the candidate pushed into the lowest slot; the top slot
  // falls off the end of the vector.
  assign hist_shifted = (hist << CODE_W) | HIST_W'(cand);

  // Debounce FSM with registered event outputs; it only moves at frame end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      cand        <= '0;
      cnt         <= '0;
      key_valid_q <= 1'b0;
      ghost_q     <= 1'b0;
      key_code_q  <= '0;
    end else begin
      key_valid_q <= 1'b0;
      ghost_q     <= 1'b0;
      if (frame_done) begin
        case (state)
          S_IDLE: begin
            if (frame_result == SINGLE) begin
              state <= S_DEBOUNCE;
              cand  <= frame_code;
              cnt   <= CNT_W'(1);
            end
          end
          S_DEBOUNCE: begin
            if (frame_result == SINGLE) begin
              if (frame_code == cand) begin
                if (debounce_met) begin
                  state       <= S_HELD;
                  key_valid_q <= 1'b1;
                  key_code_q  <= cand;
                end else begin
                  cnt <= cnt_inc;
                end
              end else begin
                cand <= frame_code;
                cnt  <= CNT_W'(1);
              end
            end else if (frame_result == MULTI) begin
              state   <= S_IDLE;
              ghost_q <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
          S_HELD: begin
            // No auto-repeat: only a clean release frame moves us on
            if (frame_result == NONE) begin
              state <= S_RELEASE;
              cnt   <= CNT_W'(1);
            end
          end
          S_RELEASE: begin
            if (frame_result == NONE) begin
              if (debounce_met) begin
                state <= S_IDLE;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              // Release bounce: back to held without a second report
              state <= S_HELD;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Key history and fill count; clear wins but still keeps a coincident report
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hist     <= '0;
      hist_cnt <= '0;
    end else if (bus.clear) begin
      hist     <= report ? HIST_W'(cand) : '0;
      hist_cnt <= report ? HCNT_W'(1) : '0;
    end else if (report) begin
      hist <= hist_shifted;
      if (hist_cnt != HCNT_W'(HIST_DEPTH)) begin
        hist_cnt <= hist_cnt + 1'b1;
      end
    end
  end

  assign bus.row         = row_drv;
  assign bus.key_valid   = key_valid_q;
  assign bus.ghost       = ghost_q;
  assign bus.key_code    = key_code_q;
  assign bus.key_history = hist;
  assign bus.hist_count  = hist_cnt;

endmodule : matrix_keypad_scanner
`default_nettype wire

// File: tb/tb_matrix_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_keypad_scanner
// Purpose  : Directed bench for the keypad scanner. A key-mask model drives
//            the column lines from the row outputs; frame-level vectors with
//            hand-computed results cover press, hold, bounce, ghost, history
//            and release debounce, followed by hand-written sequences for
//            clear, reset mid-debounce and a 2x3 parameter set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_keypad_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [15:0] keys;
  logic [3:0]  col_m;
  logic        resetn_p;
  logic [5:0]  keys_p;
  logic [2:0]  col_p;

  int checks = 0;
  int errors = 0;

  matrix_keypad_scanner_if #(.ROWS(4), .COLS(4), .HIST_DEPTH(4)) bus ();
  matrix_keypad_scanner_if #(.ROWS(2), .COLS(3), .HIST_DEPTH(4)) bus_p ();

  matrix_keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .HIST_DEPTH(4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  matrix_keypad_scanner #(
    .ROWS(2), .COLS(3), .SCAN_DIV(2), .DEBOUNCE(3), .HIST_DEPTH(4)
  ) dut_p (
    .clk    (clk),
    .resetn (resetn_p),
    .bus    (bus_p)
  );

  // Key matrix model: a pressed key pulls its column low while its row is low
  always_comb begin
    col_m = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!bus.row[r] && keys[r*4+c]) col_m[c] = 1'b0;
  end
  assign bus.col = col_m;

  always_comb begin
    col_p = 3'b111;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        if (!bus_p.row[r] && keys_p[r*3+c]) col_p[c] = 1'b0;
  end
  assign bus_p.col = col_p;

  typedef struct {
    logic [15:0] keys;
    int          reps;
    logic        exp_valid;
    logic        exp_ghost;
    logic [3:0]  exp_code;
    logic [15:0] exp_hist;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [15:0] k, input int reps, input logic v,
                     input logic g, input logic [3:0] code,
                     input logic [15:0] hist, input logic [2:0] cnt);
    vec_t e;
    e.keys = k; e.reps = reps; e.exp_valid = v; e.exp_ghost = g;
    e.exp_code = code; e.exp_hist = hist; e.exp_cnt = cnt;
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Apply one vector from a frame start; the frame-end pulse is seen right
  // after the last edge of the last frame, any other pulse is stray.
  task automatic run_vec(input int idx, input vec_t v);
    logic stray;
    logic gv, gg;
    stray = 1'b0; gv = 1'b0; gg = 1'b0;
    keys = v.keys;
    for (int f = 0; f < v.reps; f++) begin
      for (int i = 0; i < 16; i++) begin
        @(posedge clk);
        #1;
        if (f == v.reps - 1 && i == 15) begin
          gv = bus.key_valid;
          gg = bus.ghost;
        end else if (bus.key_valid || bus.ghost) begin
          stray = 1'b1;
        end
      end
    end
    chk($sformatf("v%0d_stray_pulse", idx), 32'(stray), 32'd0);
    chk($sformatf("v%0d_key_valid", idx), 32'(gv), 32'(v.exp_valid));
    chk($sformatf("v%0d_ghost", idx), 32'(gg), 32'(v.exp_ghost));
    chk($sformatf("v%0d_key_code", idx), 32'(bus.key_code), 32'(v.exp_code));
    chk($sformatf("v%0d_history", idx), 32'(bus.key_history), 32'(v.exp_hist));
    chk($sformatf("v%0d_hist_count", idx), 32'(bus.hist_count), 32'(v.exp_cnt));
  endtask

  // Count edges from the current frame start until key_valid is seen
  task automatic wait_valid(input logic use_p, output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (use_p ? bus_p.key_valid : bus.key_valid) break;
    end
  endtask

  initial begin
    int n;
    resetn = 1'b0; resetn_p = 1'b0; keys = '0; keys_p = '0;
    bus.clear = 1'b0; bus_p.clear = 1'b0;

    // keys, reps, valid, ghost, code, history, count
    add(16'h0200,  2, 0, 0, 4'd0, 16'h0000, 3'd0); // key 9 debouncing
    add(16'h0200,  1, 1, 0, 4'd9, 16'h0009, 3'd1); // accepted on frame 3
    add(16'h0200, 10, 0, 0, 4'd9, 16'h0009, 3'd1); // held, no repeat
    add(16'h0000,  3, 0, 0, 4'd9, 16'h0009, 3'd1); // release debounce
    add(16'h0020,  2, 0, 0, 4'd9, 16'h0009, 3'd1); // key 5 frames 1,2
    add(16'h0000,  1, 0, 0, 4'd9, 16'h0009, 3'd1); // bounce gap
    add(16'h0020,  2, 0, 0, 4'd9, 16'h0009, 3'd1); // frames 4,5
    add(16'h0020,  1, 1, 0, 4'd5, 16'h0095, 3'd2); // frame 6 accepts
    add(16'h0000,  3, 0, 0, 4'd5, 16'h0095, 3'd2);
    add(16'h0001,  1, 0, 0, 4'd5, 16'h0095, 3'd2); // single key 0
    add(16'h8001,  1, 0, 1, 4'd5, 16'h0095, 3'd2); // keys 0+15: ghost
    add(16'h0000,  1, 0, 0, 4'd5, 16'h0095, 3'd2);
    add(16'h0002,  3, 1, 0, 4'd1, 16'h0951, 3'd3);
    add(16'h0000,  3, 0, 0, 4'd1, 16'h0951, 3'd3);
    add(16'h0004,  3, 1, 0, 4'd2, 16'h9512, 3'd4);
    add(16'h0000,  3, 0, 0, 4'd2, 16'h9512, 3'd4);
    add(16'h0008,  3, 1, 0, 4'd3, 16'h5123, 3'd4);
    add(16'h0000,  3, 0, 0, 4'd3, 16'h5123, 3'd4);
    add(16'h0010,  3, 1, 0, 4'd4, 16'h1234, 3'd4);
    add(16'h0000,  3, 0, 0, 4'd4, 16'h1234, 3'd4);
    add(16'h0020,  3, 1, 0, 4'd5, 16'h2345, 3'd4); // wrapped history
    add(16'h0000,  3, 0, 0, 4'd5, 16'h2345, 3'd4);
    add(16'h0008,  3, 1, 0, 4'd3, 16'h3453, 3'd4); // key 3 accepted
    add(16'h0000,  2, 0, 0, 4'd3, 16'h3453, 3'd4); // short release
    add(16'h0008,  1, 0, 0, 4'd3, 16'h3453, 3'd4); // back to held
    add(16'h0000,  3, 0, 0, 4'd3, 16'h3453, 3'd4); // full release
    add(16'h0008,  3, 1, 0, 4'd3, 16'h4533, 3'd4); // second press
    add(16'h0000,  3, 0, 0, 4'd3, 16'h4533, 3'd4);

    // Reset state
    @(posedge clk);
    #1;
    resetn = 1'b1;
    chk("reset_row", 32'(bus.row), 32'h0000_000E);
    chk("reset_key_valid", 32'(bus.key_valid), 32'd0);
    chk("reset_ghost", 32'(bus.ghost), 32'd0);
    chk("reset_key_code", 32'(bus.key_code), 32'd0);
    chk("reset_history", 32'(bus.key_history), 32'd0);
    chk("reset_hist_count", 32'(bus.hist_count), 32'd0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Clear empties history but leaves key_code alone
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    chk("clear_history", 32'(bus.key_history), 32'd0);
    chk("clear_hist_count", 32'(bus.hist_count), 32'd0);
    chk("clear_key_code", 32'(bus.key_code), 32'd3);
    step(15); // realign to frame start

    // Clear on the same edge as the key 7 report
    keys = 16'h0080;
    step(32 + 15);
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    chk("clr_rpt_key_valid", 32'(bus.key_valid), 32'd1);
    chk("clr_rpt_key_code", 32'(bus.key_code), 32'd7);
    chk("clr_rpt_history", 32'(bus.key_history), 32'h0007);
    chk("clr_rpt_hist_count", 32'(bus.hist_count), 32'd1);
    keys = '0;
    step(48);

    // Reset in the middle of debouncing key 6
    keys = 16'h0040;
    step(32 + 5);
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    chk("midrst_row", 32'(bus.row), 32'h0000_000E);
    chk("midrst_key_valid", 32'(bus.key_valid), 32'd0);
    chk("midrst_key_code", 32'(bus.key_code), 32'd0);
    chk("midrst_history", 32'(bus.key_history), 32'd0);
    chk("midrst_hist_count", 32'(bus.hist_count), 32'd0);
    wait_valid(1'b0, n);
    // n edges after the frame start means key_valid is in cycle n+1
    chk("midrst_latency_cycle", 32'(n + 1), 32'd49);
    chk("midrst_key_code_after", 32'(bus.key_code), 32'd6);
    chk("midrst_history_after", 32'(bus.key_history), 32'h0006);
    keys = '0;

    // 2x3 matrix with SCAN_DIV=2: row scanning
    step(1);
    resetn_p = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("p_row_c%0d", i), 32'(bus_p.row),
          ((i / 2) % 2 == 1) ? 32'd1 : 32'd2);
      step(1);
    end

    // 2x3 matrix: key row1/col2 held from reset
    resetn_p = 1'b0;
    keys_p = 6'b100000;
    step(1);
    resetn_p = 1'b1;
    chk("p_reset_key_valid", 32'(bus_p.key_valid), 32'd0);
    wait_valid(1'b1, n);
    chk("p_latency_cycle", 32'(n + 1), 32'd13);
    chk("p_key_code", 32'(bus_p.key_code), 32'd5);
    chk("p_hist_count", 32'(bus_p.hist_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "bench timed out");
  end

endmodule : tb_matrix_keypad_scanner
`default_nettype wire
